// File: rtl/muntjac_fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muntjac_fpu_pkg
//  Purpose  : Shared FPU types: IEEE rounding modes, divide/sqrt FSM state
//             encoding and the divide/sqrt output significand width.
//  Revision : 1.0 - initial release
// ============================================================================
package muntjac_fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rounding_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_sqrt_state_e;

    // 1 integer + 52 fraction + guard + 2 extra bits
    localparam int DivSqrtSigWidth = 56;

endpackage
`default_nettype wire

// File: rtl/muntjac_fpu_div_sqrt_iter.sv
`default_nettype none
// ============================================================================
//  Module   : muntjac_fpu_div_sqrt_iter
//  Purpose  : Iterative radix-2 divide / square-root core. Produces one
//             quotient/root bit per cycle and hands an unrounded result
//             (Q1.(SigWidth-1) significand with jammed sticky) to the
//             downstream rounder. Special operands resolve immediately.
//  Ports    : clk_i/rst_ni        clock, async active-low reset
//             flush_i             abandon current operation
//             req_*               request handshake, opcode, precision, rm
//             a_*/b_*             unpacked operands and class flags
//             resp_valid_o/ready  response handshake
//             remaining *_o       rounder inputs
//  Revision : 1.0 - initial release
// ============================================================================
module muntjac_fpu_div_sqrt_iter
    import muntjac_fpu_pkg::*;
#(
    parameter int ExpWidth = 13,
    parameter int SigWidth = DivSqrtSigWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_sqrt_i,
    input  logic                req_double_i,
    input  rounding_mode_e      req_rounding_mode_i,

    input  logic                a_sign_i,
    input  logic [ExpWidth-1:0] a_exponent_i,
    input  logic [52:0]         a_significand_i,
    input  logic                a_is_zero_i,
    input  logic                a_is_inf_i,
    input  logic                a_is_nan_i,
    input  logic                a_is_snan_i,

    input  logic                b_sign_i,
    input  logic [ExpWidth-1:0] b_exponent_i,
    input  logic [52:0]         b_significand_i,
    input  logic                b_is_zero_i,
    input  logic                b_is_inf_i,
    input  logic                b_is_nan_i,
    input  logic                b_is_snan_i,

    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic                invalid_operation_o,
    output logic                divide_by_zero_o,
    output logic                use_nan_payload_o,
    output logic                double_o,
    output logic                sign_o,
    output logic                is_zero_o,
    output logic                is_nan_o,
    output logic                is_inf_o,
    output logic [ExpWidth-1:0] exponent_o,
    output logic [SigWidth-1:0] significand_o,
    output rounding_mode_e      rounding_mode_o
);

    localparam int RemWidth = SigWidth + 3;
    localparam int OpWidth  = 54;
    localparam int CntWidth = $clog2(SigWidth);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    div_sqrt_state_e       r_state;
    logic                  r_ready;
    logic                  r_resp_valid;
    logic                  r_sqrt;
    logic                  r_double;
    rounding_mode_e        r_rm;
    logic                  r_sign;
    logic                  r_invalid;
    logic                  r_dbz;
    logic                  r_zero;
    logic                  r_nan;
    logic                  r_inf;
    logic [ExpWidth-1:0]   r_exp;
    logic [RemWidth-1:0]   r_rem;   // partial remainder
    logic [OpWidth-1:0]    r_opb;   // divisor, or radicand shifted 2 bits/cycle
    logic [SigWidth-1:0]   r_res;   // quotient/root shift register
    logic [CntWidth-1:0]   r_cnt;

    // ------------------------------------------------------------------
    // Accept-time operand preparation
    // ------------------------------------------------------------------
    logic                w_a_lt_b;
    logic [OpWidth-1:0]  w_div_dividend;
    logic [OpWidth-1:0]  w_sqrt_radicand;
    logic [ExpWidth-1:0] w_div_exp;
    logic [ExpWidth-1:0] w_sqrt_exp;

    // Pre-shifting the smaller dividend keeps the quotient in [1,2).
    assign w_a_lt_b       = a_significand_i < b_significand_i;
    assign w_div_dividend = w_a_lt_b ? {a_significand_i, 1'b0} : {1'b0, a_significand_i};
    assign w_div_exp      = a_exponent_i - b_exponent_i - ExpWidth'(w_a_lt_b);

    // Odd exponents fold one factor of two into the radicand. An arithmetic
    // shift floors, so (e-1)>>>1 == e>>>1 for odd e and one shift covers both.
    assign w_sqrt_radicand = a_exponent_i[0] ? {a_significand_i, 1'b0} : {1'b0, a_significand_i};
    assign w_sqrt_exp      = $signed(a_exponent_i) >>> 1;

    // ------------------------------------------------------------------
    // Special-case classification
    // ------------------------------------------------------------------
    logic w_div_inv, w_div_nan, w_div_dbz, w_div_inf, w_div_zero;
    logic w_sq_inv, w_sq_nan, w_sq_inf, w_sq_zero;
    logic w_inv, w_nan, w_dbz, w_inf, w_zero, w_special, w_sign;

    assign w_div_inv  = a_is_snan_i | b_is_snan_i | (a_is_zero_i & b_is_zero_i)
                      | (a_is_inf_i & b_is_inf_i);
    assign w_div_nan  = w_div_inv | a_is_nan_i | b_is_nan_i;
    assign w_div_dbz  = ~w_div_nan & b_is_zero_i & ~a_is_inf_i;
    assign w_div_inf  = ~w_div_nan & (a_is_inf_i | b_is_zero_i);
    assign w_div_zero = ~w_div_nan & (a_is_zero_i | b_is_inf_i);

    assign w_sq_inv   = a_is_snan_i | (a_sign_i & ~a_is_zero_i & ~a_is_nan_i);
    assign w_sq_nan   = w_sq_inv | a_is_nan_i;
    assign w_sq_inf   = ~w_sq_nan & a_is_inf_i;
    assign w_sq_zero  = ~w_sq_nan & a_is_zero_i;

    assign w_inv     = req_sqrt_i ? w_sq_inv  : w_div_inv;
    assign w_nan     = req_sqrt_i ? w_sq_nan  : w_div_nan;
    assign w_dbz     = req_sqrt_i ? 1'b0      : w_div_dbz;
    assign w_inf     = req_sqrt_i ? w_sq_inf  : w_div_inf;
    assign w_zero    = req_sqrt_i ? w_sq_zero : w_div_zero;
    assign w_special = w_nan | w_inf | w_zero;
    // Canonical NaN is positive; a legal sqrt operand is +x or -0, so a_sign
    // is the correct sign for every non-NaN sqrt result.
    assign w_sign    = w_nan ? 1'b0 : (req_sqrt_i ? a_sign_i : (a_sign_i ^ b_sign_i));

    // ------------------------------------------------------------------
    // Shared iteration datapath: one subtractor for both operations.
    //  div : trial = rem - divisor,        rem shifts left 1 afterwards
    //  sqrt: trial = (rem<<2 | next pair) - (root<<2 | 1)
    // ------------------------------------------------------------------
    logic [RemWidth-1:0] w_minuend;
    logic [RemWidth-1:0] w_subtrahend;
    logic [RemWidth:0]   w_diff;
    logic                w_bit;
    logic [RemWidth-1:0] w_rem_kept;
    logic [RemWidth-1:0] w_rem_next;
    logic                w_last;
    logic [SigWidth-1:0] w_res_next;

    assign w_minuend    = r_sqrt ? {r_rem[RemWidth-3:0], r_opb[OpWidth-1 -: 2]} : r_rem;
    assign w_subtrahend = r_sqrt ? RemWidth'({r_res, 2'b01}) : RemWidth'(r_opb);
    assign w_diff       = {1'b0, w_minuend} - {1'b0, w_subtrahend};
    assign w_bit        = ~w_diff[RemWidth];
    assign w_rem_kept   = w_bit ? w_diff[RemWidth-1:0] : w_minuend;
    assign w_rem_next   = r_sqrt ? w_rem_kept : (w_rem_kept << 1);
    assign w_last       = (r_cnt == '0);
    // On the final bit, any leftover remainder is jammed into bit 0.
    assign w_res_next   = {r_res[SigWidth-2:0], w_bit | (w_last & (w_rem_next != '0))};

    // ------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_sqrt       <= 1'b0;
            r_double     <= 1'b0;
            r_rm         <= RNE;
            r_sign       <= 1'b0;
            r_invalid    <= 1'b0;
            r_dbz        <= 1'b0;
            r_zero       <= 1'b0;
            r_nan        <= 1'b0;
            r_inf        <= 1'b0;
            r_exp        <= '0;
            r_rem        <= '0;
            r_opb        <= '0;
            r_res        <= '0;
            r_cnt        <= '0;
        end else if (flush_i) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i && r_ready) begin
                        r_ready   <= 1'b0;
                        r_sqrt    <= req_sqrt_i;
                        r_double  <= req_double_i;
                        r_rm      <= req_rounding_mode_i;
                        r_sign    <= w_sign;
                        r_invalid <= w_inv;
                        r_dbz     <= w_dbz;
                        r_zero    <= w_zero;
                        r_nan     <= w_nan;
                        r_inf     <= w_inf;
                        r_exp     <= req_sqrt_i ? w_sqrt_exp : w_div_exp;
                        r_rem     <= req_sqrt_i ? '0 : RemWidth'(w_div_dividend);
                        r_opb     <= req_sqrt_i ? w_sqrt_radicand : {1'b0, b_significand_i};
                        r_res     <= '0;
                        r_cnt     <= CntWidth'(SigWidth - 1);
                        r_state   <= w_special ? DONE : CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_sqrt) begin
                        r_opb <= r_opb << 2;
                    end
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes; afterwards hold until taken.
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                    end else if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o         = r_ready;
    assign resp_valid_o        = r_resp_valid;
    assign invalid_operation_o = r_invalid;
    assign divide_by_zero_o    = r_dbz;
    assign use_nan_payload_o   = 1'b0;
    assign double_o            = r_double;
    assign sign_o              = r_sign;
    assign is_zero_o           = r_zero;
    assign is_nan_o            = r_nan;
    assign is_inf_o            = r_inf;
    assign exponent_o          = r_exp;
    assign significand_o       = r_res;
    assign rounding_mode_o     = r_rm;

endmodule
`default_nettype wire
